// File: rtl/hacd_comp_pkg.sv
// Shared definitions for the HACD page compressor and its matching decompressor.
// The line width comes from the AXI4 data-width macro, with 512 as the fallback.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

package hacd_comp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_META,
        ST_SEL,
        ST_TRANSFER,
        ST_DONE,
        ST_BUS_ERROR
    } comp_state_e;

    localparam int LINES_PER_PAGE = 64;
    localparam int CHUNK_LINES    = 16;
    localparam int NUM_CHUNKS     = 4;
    localparam int META_ZVEC_LSB  = 0;
    localparam int META_ZVEC_W    = 4;
    localparam int LINE_CNT_W     = 7;

    // The compressed size depends on how many chunks carry data, i.e. how many bits are clear.
    function automatic logic [2:0] count_nonzero_chunks(input logic [NUM_CHUNKS-1:0] zvec);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (!zvec[i]) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/hacd_zero_chunk_scan.sv
// Tracks which 16-line chunks of the page are entirely zero.
// Bits start at 1 and are knocked down by any non-zero line in that chunk.
module hacd_zero_chunk_scan
    import hacd_comp_pkg::*;
#(
    parameter int DATA_W = 512
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            update_i,
    input  logic [$clog2(NUM_CHUNKS)-1:0]   chunk_idx_i,
    input  logic [DATA_W-1:0]               line_data_i,
    output logic [NUM_CHUNKS-1:0]           zero_chunk_vec_o
);

    logic [NUM_CHUNKS-1:0] zero_chunk_vec_q;
    logic [NUM_CHUNKS-1:0] zero_chunk_vec_d;

    always_comb begin
        zero_chunk_vec_d = zero_chunk_vec_q;
        if (clear_i) begin
            zero_chunk_vec_d = '1;
        end else if (update_i && (|line_data_i)) begin
            zero_chunk_vec_d[chunk_idx_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zero_chunk_vec_q <= '1;
        end else begin
            zero_chunk_vec_q <= zero_chunk_vec_d;
        end
    end

    assign zero_chunk_vec_o = zero_chunk_vec_q;

endmodule

// File: rtl/hacd_compressor.sv
// Compresses one 64-line page: scan for zero chunks, emit a metadata line,
// then copy only the non-zero chunks from the read FIFO to the write FIFO.
module hacd_compressor
    import hacd_comp_pkg::*;
#(
    parameter int FIFO_PTR_WIDTH = 6,
    parameter int DATA_W         = `HACD_AXI4_DATA_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      comp_start,
    output logic [13:0]               comp_size,
    output logic                      comp_done,
    output logic                      bus_err,
    output logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr,
    output logic                      ld_rdfifo_rdptr,
    input  logic                      rdfifo_empty,
    output logic                      rd_req,
    input  logic [DATA_W-1:0]         rd_data,
    input  logic [1:0]                rd_rresp,
    input  logic                      rd_valid,
    input  logic                      wrfifo_full,
    output logic                      wr_req,
    output logic [DATA_W-1:0]         wr_data
);

    localparam int CHUNK_IDX_W = $clog2(NUM_CHUNKS);
    localparam int CHUNK_SHIFT = $clog2(CHUNK_LINES);
    localparam logic [LINE_CNT_W-1:0] LAST_SCAN_LINE  = LINE_CNT_W'(LINES_PER_PAGE - 1);
    localparam logic [LINE_CNT_W-1:0] LAST_CHUNK_LINE = LINE_CNT_W'(CHUNK_LINES - 1);

    comp_state_e                state_q, state_d;
    logic [LINE_CNT_W-1:0]      line_cnt_q, line_cnt_d;
    logic                       rd_pend_q, rd_pend_d;
    logic [NUM_CHUNKS-1:0]      chunk_done_q, chunk_done_d;
    logic [CHUNK_IDX_W-1:0]     cur_chunk_q, cur_chunk_d;
    logic [2:0]                 nz_cnt_q, nz_cnt_d;
    logic [13:0]                comp_size_q, comp_size_d;
    logic                       comp_done_q, comp_done_d;
    logic                       bus_err_q, bus_err_d;
    logic [FIFO_PTR_WIDTH-1:0]  rdptr_q, rdptr_d;
    logic                       ld_q, ld_d;
    logic                       rd_req_q, rd_req_d;
    logic                       wr_req_q, wr_req_d;
    logic [DATA_W-1:0]          wr_data_q, wr_data_d;

    logic [NUM_CHUNKS-1:0]      zero_chunk_vec;
    logic                       scan_clear;
    logic                       scan_update;
    logic                       sel_found;
    logic [CHUNK_IDX_W-1:0]     sel_idx;
    logic                       rd_ok, rd_good, rd_bad;
    logic                       can_read;

    hacd_zero_chunk_scan #(
        .DATA_W (DATA_W)
    ) u_zero_chunk_scan (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (scan_clear),
        .update_i         (scan_update),
        .chunk_idx_i      (line_cnt_q[CHUNK_SHIFT +: CHUNK_IDX_W]),
        .line_data_i      (rd_data),
        .zero_chunk_vec_o (zero_chunk_vec)
    );

    // Responses are only honoured while a read is actually outstanding.
    assign rd_ok    = rd_valid && rd_pend_q;
    assign rd_good  = rd_ok && (rd_rresp == 2'b00);
    assign rd_bad   = rd_ok && (rd_rresp != 2'b00);
    assign can_read = !rdfifo_empty && !rd_pend_q && !ld_q;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_CHUNKS - 1; k >= 0; k--) begin
            if (!zero_chunk_vec[k] && !chunk_done_q[k]) begin
                sel_found = 1'b1;
                sel_idx   = CHUNK_IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (comp_start && !rdfifo_empty) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (rd_bad) begin
                    state_d = ST_BUS_ERROR;
                end else if (rd_good && (line_cnt_q == LAST_SCAN_LINE)) begin
                    state_d = ST_META;
                end
            end
            ST_META: begin
                if (!wrfifo_full) begin
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                state_d = sel_found ? ST_TRANSFER : ST_DONE;
            end
            ST_TRANSFER: begin
                if (rd_bad) begin
                    state_d = ST_BUS_ERROR;
                end else if (rd_good && (line_cnt_q == LAST_CHUNK_LINE)) begin
                    state_d = ST_SEL;
                end
            end
            ST_DONE: begin
                if (!comp_start) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS_ERROR: begin
                state_d = ST_BUS_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        line_cnt_d   = line_cnt_q;
        chunk_done_d = chunk_done_q;
        cur_chunk_d  = cur_chunk_q;
        nz_cnt_d     = nz_cnt_q;
        rdptr_d      = rdptr_q;
        wr_data_d    = wr_data_q;
        ld_d         = 1'b0;
        rd_req_d     = 1'b0;
        wr_req_d     = 1'b0;
        scan_clear   = 1'b0;
        scan_update  = 1'b0;
        bus_err_d    = bus_err_q | rd_bad;

        case (state_q)
            ST_IDLE: begin
                scan_clear   = 1'b1;
                chunk_done_d = '0;
                nz_cnt_d     = '0;
                if (comp_start && !rdfifo_empty) begin
                    ld_d       = 1'b1;
                    rdptr_d    = '0;
                    line_cnt_d = '0;
                end
            end
            ST_SCAN: begin
                rd_req_d = can_read;
                if (rd_good) begin
                    scan_update = 1'b1;
                    line_cnt_d  = line_cnt_q + 1'b1;
                end
            end
            ST_META: begin
                if (!wrfifo_full) begin
                    wr_req_d = 1'b1;
                    wr_data_d = '0;
                    wr_data_d[META_ZVEC_LSB +: META_ZVEC_W] = zero_chunk_vec;
                    nz_cnt_d = count_nonzero_chunks(zero_chunk_vec);
                end
            end
            ST_SEL: begin
                if (sel_found) begin
                    ld_d        = 1'b1;
                    rdptr_d     = FIFO_PTR_WIDTH'(32'(sel_idx) * CHUNK_LINES);
                    cur_chunk_d = sel_idx;
                    line_cnt_d  = '0;
                end
            end
            ST_TRANSFER: begin
                // Full is checked before the read, the FIFO reserves a slot for the in-flight line.
                rd_req_d = can_read && !wrfifo_full;
                if (rd_good) begin
                    wr_req_d   = 1'b1;
                    wr_data_d  = rd_data;
                    line_cnt_d = line_cnt_q + 1'b1;
                    if (line_cnt_q == LAST_CHUNK_LINE) begin
                        chunk_done_d[cur_chunk_q] = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        rd_pend_d   = (rd_pend_q && !rd_ok) || rd_req_d;
        comp_done_d = (state_d == ST_DONE);
        comp_size_d = comp_done_d ? 14'((32'(nz_cnt_d) * CHUNK_LINES + 1) * (DATA_W / 8)) : 14'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            chunk_done_q <= '0;
            cur_chunk_q  <= '0;
            nz_cnt_q     <= '0;
            comp_size_q  <= '0;
            comp_done_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            rdptr_q      <= '0;
            ld_q         <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            wr_data_q    <= '0;
        end else begin
            line_cnt_q   <= line_cnt_d;
            rd_pend_q    <= rd_pend_d;
            chunk_done_q <= chunk_done_d;
            cur_chunk_q  <= cur_chunk_d;
            nz_cnt_q     <= nz_cnt_d;
            comp_size_q  <= comp_size_d;
            comp_done_q  <= comp_done_d;
            bus_err_q    <= bus_err_d;
            rdptr_q      <= rdptr_d;
            ld_q         <= ld_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign comp_size       = comp_size_q;
    assign comp_done       = comp_done_q;
    assign bus_err         = bus_err_q;
    assign rdfifo_rdptr    = rdptr_q;
    assign ld_rdfifo_rdptr = ld_q;
    assign rd_req          = rd_req_q;
    assign wr_req          = wr_req_q;
    assign wr_data         = wr_data_q;

endmodule

// File: tb/tb_hacd_compressor.sv
// Bench for hacd_compressor: FIFO models, write scoreboard, table of page runs,
// plus hand-written bus-error and mid-page reset sequences.
module tb_hacd_compressor;

    localparam int DW = 512;
    localparam int PW = 6;

    typedef struct {
        int          pattern;
        bit          full_hold;
        bit          stall;
        logic [3:0]  exp_meta;
        int          exp_size;
        int          exp_writes;
    } vec_t;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           comp_start = 1'b0;
    logic [13:0]    comp_size;
    logic           comp_done;
    logic           bus_err;
    logic [PW-1:0]  rdfifo_rdptr;
    logic           ld_rdfifo_rdptr;
    logic           rdfifo_empty = 1'b0;
    logic           rd_req;
    logic [DW-1:0]  rd_data = '0;
    logic [1:0]     rd_rresp = 2'b00;
    logic           rd_valid = 1'b0;
    logic           wrfifo_full = 1'b0;
    logic           wr_req;
    logic [DW-1:0]  wr_data;

    logic [DW-1:0]  page_mem [64];
    logic [DW-1:0]  exp_wr_q [$];
    logic [PW-1:0]  exp_ld_q [$];
    logic [DW-1:0]  first_wr;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0]  fifo_ptr = '0;
    bit             resp_pending = 1'b0;
    int             resp_delay = 0;
    int             resp_idx = 0;
    int             rd_idx = 0;
    int             err_line = -1;
    int             wr_seen = 0;
    int             viol = 0;
    int             post_err_act = 0;
    bit             prev_ld = 1'b0;
    bit             stall_en = 1'b0;
    bit             full_hold_en = 1'b0;
    bit             full_started = 1'b0;
    int             full_cnt = 0;
    bit             done_seen = 1'b0;

    vec_t vecs [5];

    hacd_compressor #(
        .FIFO_PTR_WIDTH (PW),
        .DATA_W         (DW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .comp_start      (comp_start),
        .comp_size       (comp_size),
        .comp_done       (comp_done),
        .bus_err         (bus_err),
        .rdfifo_rdptr    (rdfifo_rdptr),
        .ld_rdfifo_rdptr (ld_rdfifo_rdptr),
        .rdfifo_empty    (rdfifo_empty),
        .rd_req          (rd_req),
        .rd_data         (rd_data),
        .rd_rresp        (rd_rresp),
        .rd_valid        (rd_valid),
        .wrfifo_full     (wrfifo_full),
        .wr_req          (wr_req),
        .wr_data         (wr_data)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event required=none", name);
    endtask

    // Environment: read-FIFO responder, write-FIFO scoreboard and protocol monitors, all on the falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            resp_pending = 1'b0;
            rd_valid     = 1'b0;
            rd_rresp     = 2'b00;
            prev_ld      = 1'b0;
            full_cnt     = 0;
            wrfifo_full  = 1'b0;
        end else begin
            if (rd_req && (resp_pending || prev_ld || rdfifo_empty)) viol++;
            if (rd_req && wrfifo_full && rd_idx >= 64) viol++;
            if (comp_done) done_seen = 1'b1;
            if (bus_err && (rd_req || wr_req)) post_err_act++;
            prev_ld = ld_rdfifo_rdptr;

            if (ld_rdfifo_rdptr) begin
                if (exp_ld_q.size() == 0) begin
                    reportFail("unexpected_ld");
                end else begin
                    checkOutput("ld_rdptr", DW'(rdfifo_rdptr), DW'(exp_ld_q.pop_front()));
                end
                fifo_ptr = rdfifo_rdptr;
            end

            if (wr_req) begin
                if (wr_seen == 0) first_wr = wr_data;
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    reportFail("unexpected_wr");
                end else begin
                    checkOutput("wr_data", wr_data, exp_wr_q.pop_front());
                end
            end

            rd_valid = 1'b0;
            rd_rresp = 2'b00;
            if (resp_pending) begin
                if (resp_delay == 0) begin
                    rd_valid     = 1'b1;
                    rd_data      = page_mem[fifo_ptr];
                    rd_rresp     = (resp_idx == err_line) ? 2'd2 : 2'd0;
                    fifo_ptr     = fifo_ptr + 1'b1;
                    resp_pending = 1'b0;
                end else begin
                    resp_delay--;
                end
            end
            if (rd_req) begin
                resp_pending = 1'b1;
                resp_delay   = int'($urandom_range(0, 2));
                resp_idx     = rd_idx;
                rd_idx++;
            end

            if (full_hold_en && !full_started && wr_seen >= 20) begin
                full_started = 1'b1;
                full_cnt     = 20;
            end
            if (full_cnt > 0) begin
                wrfifo_full = 1'b1;
                full_cnt--;
            end else begin
                wrfifo_full = 1'b0;
            end
            rdfifo_empty = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    task automatic fill_page(input int pat);
        for (int i = 0; i < 64; i++) begin
            logic [DW-1:0] v;
            v = '0;
            case (pat)
                1: if (i >= 32 && i < 48) v = DW'(i);
                2, 3: begin
                    v = DW'(i + 1);
                    v[DW-1 -: 16] = 16'(i * 7 + 3);
                end
                4: begin
                    if (i == 20) v = DW'(32'hABCD);
                    if (i == 63) v[DW-1] = 1'b1;
                end
                default: v = '0;
            endcase
            page_mem[i] = v;
        end
    endtask

    task automatic build_expected();
        logic [3:0] zv;
        zv = 4'hF;
        exp_wr_q.delete();
        exp_ld_q.delete();
        for (int c = 0; c < 4; c++)
            for (int l = 0; l < 16; l++)
                if (page_mem[c * 16 + l] != '0) zv[c] = 1'b0;
        exp_wr_q.push_back(DW'(zv));
        exp_ld_q.push_back('0);
        for (int c = 0; c < 4; c++) begin
            if (!zv[c]) begin
                exp_ld_q.push_back(PW'(c * 16));
                for (int l = 0; l < 16; l++) exp_wr_q.push_back(page_mem[c * 16 + l]);
            end
        end
    endtask

    task automatic reset_env_counters();
        rd_idx       = 0;
        wr_seen      = 0;
        viol         = 0;
        post_err_act = 0;
        done_seen    = 1'b0;
        full_started = 1'b0;
        first_wr     = '1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit got_done;
        fill_page(v.pattern);
        build_expected();
        reset_env_counters();
        stall_en     = v.stall;
        full_hold_en = v.full_hold;
        @(negedge clk_i);
        comp_start = 1'b1;
        got_done = 1'b0;
        for (int i = 0; i < 4000 && !got_done; i++) begin
            @(negedge clk_i);
            got_done = comp_done;
        end
        checkOutput("done_reached", DW'(got_done), DW'(1));
        checkOutput("comp_size", DW'(comp_size), DW'(v.exp_size));
        checkOutput("meta", first_wr, DW'(v.exp_meta));
        checkOutput("write_count", DW'(wr_seen), DW'(v.exp_writes));
        checkOutput("writes_left", DW'(exp_wr_q.size()), DW'(0));
        checkOutput("loads_left", DW'(exp_ld_q.size()), DW'(0));
        checkOutput("protocol", DW'(viol), DW'(0));
        repeat (4) @(negedge clk_i);
        checkOutput("done_held", DW'({comp_done, comp_size}), DW'({1'b1, 14'(v.exp_size)}));
        comp_start = 1'b0;
        @(negedge clk_i);
        checkOutput("done_drop", DW'(comp_done), DW'(0));
        stall_en     = 1'b0;
        full_hold_en = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic check_outputs_idle(input string name);
        checkOutput(name, DW'({bus_err, comp_done, comp_size, rd_req, wr_req, ld_rdfifo_rdptr}), DW'(0));
    endtask

    initial begin
        vecs[0] = '{pattern: 0, full_hold: 1'b0, stall: 1'b0, exp_meta: 4'hF, exp_size: 64,   exp_writes: 1};
        vecs[1] = '{pattern: 1, full_hold: 1'b0, stall: 1'b0, exp_meta: 4'hB, exp_size: 1088, exp_writes: 17};
        vecs[2] = '{pattern: 2, full_hold: 1'b0, stall: 1'b0, exp_meta: 4'h0, exp_size: 4160, exp_writes: 65};
        vecs[3] = '{pattern: 3, full_hold: 1'b1, stall: 1'b1, exp_meta: 4'h0, exp_size: 4160, exp_writes: 65};
        vecs[4] = '{pattern: 4, full_hold: 1'b0, stall: 1'b0, exp_meta: 4'h5, exp_size: 2112, exp_writes: 33};

        repeat (3) @(negedge clk_i);
        check_outputs_idle("reset_outputs");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 5; i++) begin
            $display("[TB] page run %0d pattern %0d", i, vecs[i].pattern);
            applyStimulus(vecs[i]);
        end

        $display("[TB] bus error on scan line 5");
        fill_page(2);
        exp_wr_q.delete();
        exp_ld_q.delete();
        exp_ld_q.push_back('0);
        reset_env_counters();
        err_line = 5;
        @(negedge clk_i);
        comp_start = 1'b1;
        for (int i = 0; i < 500 && !bus_err; i++) @(negedge clk_i);
        checkOutput("bus_err_set", DW'(bus_err), DW'(1));
        repeat (50) @(negedge clk_i);
        checkOutput("err_reads", DW'(rd_idx), DW'(6));
        checkOutput("err_no_write", DW'(wr_seen), DW'(0));
        checkOutput("err_quiet", DW'(post_err_act), DW'(0));
        checkOutput("err_no_done", DW'(done_seen), DW'(0));
        checkOutput("err_sticky", DW'(bus_err), DW'(1));
        comp_start = 1'b0;
        rst_i = 1'b1;
        err_line = -1;
        @(negedge clk_i);
        check_outputs_idle("err_reset_outputs");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("[TB] reset during transfer");
        fill_page(2);
        build_expected();
        reset_env_counters();
        @(negedge clk_i);
        comp_start = 1'b1;
        for (int i = 0; i < 2000 && wr_seen < 8; i++) @(negedge clk_i);
        checkOutput("abort_reached", DW'(wr_seen >= 8), DW'(1));
        #1;
        rst_i = 1'b1;
        comp_start = 1'b0;
        exp_wr_q.delete();
        exp_ld_q.delete();
        repeat (2) @(negedge clk_i);
        check_outputs_idle("abort_reset_outputs");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        applyStimulus(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hacd_compressor.md
Name: hacd_compressor

Overview:
- Upstream counterpart of the HACD page decompressor.
- Takes one 64-line page staged in the random-access read FIFO and classifies each 16-line chunk as all-zero or non-zero.
- Emits one metadata line, then only the non-zero chunks, into the write FIFO, and reports the compressed size in bytes.
- The output stream is exactly the format the decompressor consumes.

Parameters:
- FIFO_PTR_WIDTH, 6, read-FIFO pointer width (64-entry page buffer).
- DATA_W, `HACD_AXI4_DATA_WIDTH (512), line width in bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- comp_start  in  1  level request; page fully present in read FIFO.
- comp_size  out  14  compressed size in bytes, valid while comp_done=1.
- comp_done  out  1  held high from completion until comp_start falls.
- bus_err  out  1  sticky error flag.
- rdfifo_rdptr  out  FIFO_PTR_WIDTH  read-pointer load value.
- ld_rdfifo_rdptr  out  1  one-cycle pulse; FIFO adopts rdfifo_rdptr next cycle.
- rdfifo_empty  in  1  no readable entry at current pointer.
- rd_req  out  1  one-cycle read pulse.
- rd_data  in  DATA_W  read data.
- rd_rresp  in  2  response; 0 = OKAY.
- rd_valid  in  1  rd_data/rd_rresp valid, ≥1 cycle after rd_req.
- wrfifo_full  in  1  write FIFO cannot accept.
- wr_req  out  1  one-cycle write pulse.
- wr_data  out  DATA_W  write data, valid with wr_req.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, zero_chunk_vec=4'hF, nz_cnt=0. Applies immediately at any point, including mid-page; no partial writes complete after reset.
- Outputs are registered.
- Read rule:
  - At most one outstanding read.
  - rd_req is pulsed only when !rdfifo_empty, no read is outstanding, no ld_rdfifo_rdptr pulse occurred in the previous cycle, and (TRANSFER only) !wrfifo_full.
  - The next rd_req is never issued before the rd_valid for the previous one.
- Any rd_valid with rd_rresp!=0 → BUS_ERROR: bus_err=1, no further rd_req/wr_req, exit only by reset.
- States:
  - IDLE:
    - comp_start && !rdfifo_empty → SCAN.
    - Pulse ld_rdfifo_rdptr with rdptr=0; clear line_cnt; set zero_chunk_vec=4'hF.
  - SCAN:
    - Read lines 0..63 in order.
    - On each rd_valid: if rd_data!=0, clear zero_chunk_vec[line_cnt[5:4]]; then line_cnt++.
    - After the 64th rd_valid → META.
  - META:
    - When !wrfifo_full, pulse wr_req with wr_data = {DATA_W-4 zeros, zero_chunk_vec}.
    - Bit k=1 means chunk k is all zero.
    - nz_cnt = number of 0 bits in zero_chunk_vec.
    - Go to SEL.
  - SEL:
    - Pick the lowest k not yet done and with zero_chunk_vec[k]=0.
    - Pulse ld_rdfifo_rdptr with rdptr=16*k (0,16,32,48), clear line_cnt, go to TRANSFER.
    - If no such k → DONE.
  - TRANSFER:
    - Read 16 lines.
    - Each rd_valid produces wr_req=1, wr_data=rd_data in the next cycle.
    - After 16 writes, mark chunk k done and return to SEL.
  - DONE:
    - comp_done=1 and comp_size=(1+16*nz_cnt)*DATA_W/8 held while comp_start=1.
    - comp_start=0 → IDLE, comp_done=0 next cycle.
- Write rule:
  - wrfifo_full is checked before the read is issued.
  - The write FIFO guarantees one free slot for the in-flight line.
  - wr_req is never asserted in a cycle where wrfifo_full was sampled high before issuing that line's read.
- comp_start falling before DONE: ignored, operation completes.
- rdfifo_empty mid-SCAN/TRANSFER: stall, no timeout.
- Width: comp_size max 65*64=4160 < 2^14. Incompressible pages (nz_cnt=4) are still emitted; comp_size=4160 is the caller's signal.

Decomposition:
- Package hacd_comp_pkg holds:
  - state enum;
  - LINES_PER_PAGE=64, CHUNK_LINES=16, NUM_CHUNKS=4;
  - META_ZVEC_LSB=0, META_ZVEC_W=4.
- The decompressor also imports it.
- Sub-module hacd_zero_chunk_scan holds zero_chunk_vec and per-line OR-reduction, with clear/update/chunk-index inputs.

Test Plan:
- All-zero page → 1 write, data=0xF, comp_size=64, comp_done held until comp_start=0.
- Only chunk 2 non-zero (lines 32..47 = index value) → meta 0xB, one load with rdptr=32, 16 writes of lines 32..47 in order, comp_size=1088.
- All lines non-zero → meta 0x0, loads 0/16/32/48, 65 writes total, comp_size=4160.
- wrfifo_full held 20 cycles mid-TRANSFER → no rd_req while full, no line lost/duplicated, output order preserved.
- rd_rresp=2 on line 5 of SCAN → bus_err=1, zero wr_req thereafter, comp_done never asserts; rst_i pulse → IDLE, all outputs 0.
- rst_i asserted in TRANSFER line 7, then new page run → fresh correct stream with no residue from the aborted page.
